// File: rtl/cpu_pkg.sv
// cpu_pkg: shared word width, opcode and PCSrc encodings, instruction field positions.
package cpu_pkg;
    localparam int WORD_W = 16;
    typedef enum logic [3:0] {
        OP_AND, OP_OR, OP_XOR, OP_NOT, OP_ADD, OP_SUB, OP_SHL, OP_SHR,
        OP_LD, OP_SV, OP_LI, OP_BEQ, OP_BNE, OP_JMP, OP_CALL, OP_RET
    } opcode_e;
    typedef enum logic [1:0] {PC_INC, PC_BRANCH, PC_JUMP, PC_RET} pcsrc_e;
    localparam int OPC_HI = 15;
    localparam int OPC_LO = 12;
    localparam int JMP_HI = 11;
    localparam int BR_HI = 5;
    localparam int BR_LO = 1;
    localparam int MODE_BIT = 0;
    function automatic logic [WORD_W-1:0] sext_br(input logic [BR_HI-BR_LO:0] off);
        return {{(WORD_W-BR_HI+BR_LO-1){off[BR_HI-BR_LO]}}, off};
    endfunction
endpackage

// File: rtl/return_addr_stack.sv
// return_addr_stack: circular return-address stack; a push when full overwrites the oldest entry.
module return_addr_stack
    import cpu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter logic [WORD_W-1:0] EMPTY_VAL = '0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [WORD_W-1:0] push_data,
    output logic [WORD_W-1:0] pop_data,
    output logic              overflow,
    output logic              underflow
);
    localparam int AW = $clog2(DEPTH);
    logic [WORD_W-1:0] mem_q [DEPTH];
    logic [WORD_W-1:0] mem_d [DEPTH];
    logic [AW-1:0] top_q, top_d;
    logic [AW:0] cnt_q, cnt_d;
    logic full, empty;
    assign full = cnt_q == (AW+1)'(DEPTH);
    assign empty = cnt_q == '0;
    assign overflow = push && full;
    assign underflow = pop && empty;
    assign pop_data = empty ? EMPTY_VAL : mem_q[top_q - AW'(1)];
    always_comb begin
        mem_d = mem_q;
        top_d = top_q;
        cnt_d = cnt_q;
        if (push) begin
            mem_d[top_q] = push_data;
            top_d = top_q + AW'(1);
            cnt_d = full ? cnt_q : cnt_q + (AW+1)'(1);
        end else if (pop && !empty) begin
            top_d = top_q - AW'(1);
            cnt_d = cnt_q - (AW+1)'(1);
        end
    end
    always_ff @(posedge clock) begin
        mem_q <= mem_d;
        if (reset) begin
            top_q <= '0;
            cnt_q <= '0;
        end else begin
            top_q <= top_d;
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC, next-PC mux, instruction-memory fetch handshake and instruction register.
// Define INSTR_FETCH_RAS_EN to use the internal return-address stack instead of ret_addr_ext.
module instr_fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC = 16'h0000,
    parameter int RAS_DEPTH = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enIF,
    input  logic [1:0]        PCSrc,
    input  logic [WORD_W-1:0] ret_addr_ext,
    output logic [WORD_W-1:0] imem_addr,
    output logic              imem_req,
    input  logic [WORD_W-1:0] imem_rdata,
    input  logic              imem_ack,
    output logic [WORD_W-1:0] instr,
    output logic [3:0]        OPCODE,
    output logic              modeBit,
    output logic [WORD_W-1:0] pc,
    output logic              fetch_done,
    output logic              ras_err
);
    typedef enum logic [1:0] {IDLE, REQ, DONE} state_e;
    state_e state_q, state_d;
    logic [WORD_W-1:0] pc_q, pc_d, instr_q, instr_d, ret_addr;
    logic first_q, first_d, advance;
    // The very first fetch after reset reads RESET_PC itself, so it skips the PC update.
    assign advance = state_q == IDLE && enIF && !first_q;
`ifdef INSTR_FETCH_RAS_EN
    logic push, pop, ovf, unf, ras_err_q, ras_err_d;
    assign push = advance && PCSrc == PC_JUMP && instr_q[OPC_HI:OPC_LO] == OP_CALL;
    assign pop = advance && PCSrc == PC_RET;
    assign ras_err_d = ras_err_q | ovf | unf;
    assign ras_err = ras_err_q;
    return_addr_stack #(.DEPTH(RAS_DEPTH), .EMPTY_VAL(RESET_PC)) u_ras (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .pop       (pop),
        .push_data (pc_q + WORD_W'(1)),
        .pop_data  (ret_addr),
        .overflow  (ovf),
        .underflow (unf)
    );
    always_ff @(posedge clock) ras_err_q <= reset ? 1'b0 : ras_err_d;
`else
    assign ret_addr = ret_addr_ext;
    assign ras_err = 1'b0;
`endif
    always_comb begin
        state_d = state_q;
        pc_d = pc_q;
        instr_d = instr_q;
        first_d = first_q;
        if (state_q == IDLE && enIF) begin
            state_d = REQ;
            first_d = 1'b0;
        end
        if (advance)
            pc_d = PCSrc == PC_INC    ? pc_q + WORD_W'(1) :
                   PCSrc == PC_BRANCH ? pc_q + sext_br(instr_q[BR_HI:BR_LO]) :
                   PCSrc == PC_JUMP   ? {pc_q[WORD_W-1:JMP_HI+1], instr_q[JMP_HI:0]} : ret_addr;
        if (state_q == REQ && imem_ack) begin
            state_d = DONE;
            instr_d = imem_rdata;
        end
        if (state_q == DONE) state_d = IDLE;
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            pc_q <= RESET_PC;
            instr_q <= '0;
            first_q <= 1'b1;
        end else begin
            state_q <= state_d;
            pc_q <= pc_d;
            instr_q <= instr_d;
            first_q <= first_d;
        end
    end
    assign imem_addr = pc_q;
    assign pc = pc_q;
    assign imem_req = state_q == REQ;
    assign fetch_done = state_q == DONE;
    assign instr = instr_q;
    assign OPCODE = instr_q[OPC_HI:OPC_LO];
    assign modeBit = instr_q[MODE_BIT];
endmodule
